// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampled start/data/parity/stop capture with a
// single-entry holding register and sticky overrun for the register file.
module uart_rx_core #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              rx_sample_pulse,
  input  logic              rxd,
  input  logic              rx_en,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              rx_rd,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              rx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] MID_CNT  = 4'(OVS/2 - 1);
  localparam logic [3:0] LAST_CNT = 4'(OVS - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  state_t            state;
  logic              rxd_m, rxd_s;
  logic              armed;
  logic [3:0]        sample_cnt;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              perr_q;
  logic              done;

  // Frame completes on the pulse that samples mid-stop
  assign done = rx_en && rx_sample_pulse && (state == STOP) && (sample_cnt == LAST_CNT);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rxd_m      <= 1'b1;
      rxd_s      <= 1'b1;
      state      <= IDLE;
      rx_busy    <= 1'b0;
      armed      <= 1'b0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      perr_q     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;

      if (!rx_en) begin
        state      <= IDLE;
        rx_busy    <= 1'b0;
        armed      <= 1'b0;
        sample_cnt <= '0;
        bit_cnt    <= '0;
      end else if (rx_sample_pulse) begin
        case (state)
          IDLE: begin
            if (armed && !rxd_s) begin
              state      <= START;
              rx_busy    <= 1'b1;
              sample_cnt <= '0;
            end else if (rxd_s) begin
              armed <= 1'b1;
            end
          end
          START: begin
            if (sample_cnt == MID_CNT) begin
              sample_cnt <= '0;
              if (rxd_s) begin
                state   <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end else begin
              sample_cnt <= sample_cnt + 4'd1;
            end
          end
          DATA: begin
            if (sample_cnt == LAST_CNT) begin
              shreg      <= {rxd_s, shreg[DATA_W-1:1]};
              sample_cnt <= '0;
              if (bit_cnt == LAST_BIT) state <= parity_en ? PARITY : STOP;
              else                     bit_cnt <= bit_cnt + 3'd1;
            end else begin
              sample_cnt <= sample_cnt + 4'd1;
            end
          end
          PARITY: begin
            if (sample_cnt == LAST_CNT) begin
              perr_q     <= ((^shreg) ^ rxd_s) != parity_odd;
              sample_cnt <= '0;
              state      <= STOP;
            end else begin
              sample_cnt <= sample_cnt + 4'd1;
            end
          end
          STOP: begin
            if (sample_cnt == LAST_CNT) begin
              sample_cnt <= '0;
              state      <= IDLE;
              rx_busy    <= 1'b0;
              // A low stop (break) disarms until the line is seen high again
              armed      <= rxd_s;
            end else begin
              sample_cnt <= sample_cnt + 4'd1;
            end
          end
          default: begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end

      if (err_clr) overrun <= 1'b0;

      if (done) begin
        if (!rx_valid || rx_rd) begin
          rx_data    <= shreg;
          parity_err <= parity_en & perr_q;
          frame_err  <= ~rxd_s;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_rd) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: pulse every 4 ACLK, 64 ACLK per bit.
module tb_uart_rx_core;

  logic       ACLK = 1'b0;
  logic       ARESET, rx_sample_pulse, rxd, rx_en, parity_en, parity_odd, rx_rd, err_clr;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, rx_busy;

  int checks = 0;
  int errors = 0;
  int pcnt   = 0;

  uart_rx_core #(.DATA_W(8), .OVS(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .rx_sample_pulse(rx_sample_pulse), .rxd(rxd),
    .rx_en(rx_en), .parity_en(parity_en), .parity_odd(parity_odd), .rx_rd(rx_rd),
    .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    rx_sample_pulse = 1'b0;
    forever begin
      @(posedge ACLK); #1;
      pcnt++;
      rx_sample_pulse = (pcnt % 4 == 0);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start, 8 data bits LSB-first, optional parity, stop; line left at stop level
  task automatic send_frame(input logic [7:0] d, input bit par, input logic pbit, input logic stopb);
    rxd = 1'b0; wait_cyc(64);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i]; wait_cyc(64);
    end
    if (par) begin
      rxd = pbit; wait_cyc(64);
    end
    rxd = stopb; wait_cyc(64);
  endtask

  task automatic read_word();
    rx_rd = 1'b1; wait_cyc(1);
    rx_rd = 1'b0; wait_cyc(1);
  endtask

  initial begin
    ARESET = 1'b1; rxd = 1'b1; rx_en = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    rx_rd = 1'b0; err_clr = 1'b0;
    wait_cyc(4);
    check("rst_data",  32'(rx_data), 32'h0);
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_perr",  32'(parity_err), 32'h0);
    check("rst_ferr",  32'(frame_err), 32'h0);
    check("rst_ovr",   32'(overrun), 32'h0);
    check("rst_busy",  32'(rx_busy), 32'h0);
    ARESET = 1'b0;
    wait_cyc(128);

    // 8N1 0xA5
    send_frame(8'hA5, 0, 1'b0, 1'b1);
    rxd = 1'b1; wait_cyc(8);
    check("a5_valid", 32'(rx_valid), 32'h1);
    check("a5_data",  32'(rx_data), 32'hA5);
    check("a5_perr",  32'(parity_err), 32'h0);
    check("a5_ferr",  32'(frame_err), 32'h0);
    check("a5_busy",  32'(rx_busy), 32'h0);
    read_word();
    check("a5_rd_valid", 32'(rx_valid), 32'h0);
    check("a5_rd_data",  32'(rx_data), 32'hA5);
    wait_cyc(64);

    // Even parity, 0x03: parity bit 1 is wrong, 0 is right
    parity_en = 1'b1; parity_odd = 1'b0;
    send_frame(8'h03, 1, 1'b1, 1'b1);
    rxd = 1'b1; wait_cyc(8);
    check("p1_data",  32'(rx_data), 32'h03);
    check("p1_perr",  32'(parity_err), 32'h1);
    read_word(); wait_cyc(64);
    send_frame(8'h03, 1, 1'b0, 1'b1);
    rxd = 1'b1; wait_cyc(8);
    check("p0_valid", 32'(rx_valid), 32'h1);
    check("p0_data",  32'(rx_data), 32'h03);
    check("p0_perr",  32'(parity_err), 32'h0);
    read_word(); wait_cyc(64);
    parity_en = 1'b0;

    // False start: low for 4 pulses only
    rxd = 1'b0; wait_cyc(16);
    check("fs_busy_on", 32'(rx_busy), 32'h1);
    rxd = 1'b1; wait_cyc(64);
    check("fs_busy_off", 32'(rx_busy), 32'h0);
    check("fs_valid",    32'(rx_valid), 32'h0);

    // 0x55 with low stop, line held low 3 bits total
    send_frame(8'h55, 0, 1'b0, 1'b0);
    wait_cyc(128);
    check("brk_valid", 32'(rx_valid), 32'h1);
    check("brk_data",  32'(rx_data), 32'h55);
    check("brk_ferr",  32'(frame_err), 32'h1);
    check("brk_busy",  32'(rx_busy), 32'h0);
    check("brk_ovr",   32'(overrun), 32'h0);
    read_word();
    rxd = 1'b1; wait_cyc(128);
    check("brk_idle_valid", 32'(rx_valid), 32'h0);

    // Two frames without a read -> overrun, first word kept
    send_frame(8'h11, 0, 1'b0, 1'b1);
    rxd = 1'b1; wait_cyc(64);
    send_frame(8'h22, 0, 1'b0, 1'b1);
    rxd = 1'b1; wait_cyc(8);
    check("ovr_valid", 32'(rx_valid), 32'h1);
    check("ovr_data",  32'(rx_data), 32'h11);
    check("ovr_ferr",  32'(frame_err), 32'h0);
    check("ovr_set",   32'(overrun), 32'h1);
    err_clr = 1'b1; wait_cyc(1);
    err_clr = 1'b0; wait_cyc(1);
    check("ovr_clr",   32'(overrun), 32'h0);
    check("ovr_keep",  32'(rx_valid), 32'h1);
    read_word(); wait_cyc(64);

    // Reset during data bit 4
    rxd = 1'b0; wait_cyc(64);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0] ? 1'b0 : 1'b1; wait_cyc(64);
    end
    rxd = 1'b0; wait_cyc(32);
    check("mid_busy_pre", 32'(rx_busy), 32'h1);
    ARESET = 1'b1; wait_cyc(1);
    ARESET = 1'b0;
    check("mid_busy",  32'(rx_busy), 32'h0);
    check("mid_valid", 32'(rx_valid), 32'h0);
    check("mid_data",  32'(rx_data), 32'h0);
    rxd = 1'b1; wait_cyc(128);
    check("mid_idle_valid", 32'(rx_valid), 32'h0);
    send_frame(8'h3C, 0, 1'b0, 1'b1);
    rxd = 1'b1; wait_cyc(8);
    check("3c_valid", 32'(rx_valid), 32'h1);
    check("3c_data",  32'(rx_data), 32'h3C);
    check("3c_ferr",  32'(frame_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
